// File: rtl/mem_arbiter_if.sv
// Bundle of request-side, memory-side and status signals for mem_arbiter.
// The arbiter uses the slave modport; the environment (caches/memory) uses master.
interface mem_arbiter_if #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 32
);
  logic              req0_enable_i;
  logic              req0_write_i;
  logic [ADDR_W-1:0] req0_addr_i;
  logic [DATA_W-1:0] req0_data_i;
  logic              req0_ack_o;
  logic              req1_enable_i;
  logic              req1_write_i;
  logic [ADDR_W-1:0] req1_addr_i;
  logic [DATA_W-1:0] req1_data_i;
  logic              req1_ack_o;
  logic [DATA_W-1:0] rd_data_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_data_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic              busy_o;
  logic              timeout_o;

  modport slave (
    input  req0_enable_i, req0_write_i, req0_addr_i, req0_data_i,
    input  req1_enable_i, req1_write_i, req1_addr_i, req1_data_i,
    input  mem_data_i, mem_ack_i,
    output req0_ack_o, req1_ack_o, rd_data_o,
    output mem_data_o, mem_addr_o, mem_enable_o, mem_write_o,
    output busy_o, timeout_o
  );

  modport master (
    output req0_enable_i, req0_write_i, req0_addr_i, req0_data_i,
    output req1_enable_i, req1_write_i, req1_addr_i, req1_data_i,
    output mem_data_i, mem_ack_i,
    input  req0_ack_o, req1_ack_o, rd_data_o,
    input  mem_data_o, mem_addr_o, mem_enable_o, mem_write_o,
    input  busy_o, timeout_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory line port between I-side refill (port 0)
// and dcache (port 1); holds the captured request until mem_ack_i, with a sticky watchdog.
module mem_arbiter #(
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  localparam int unsigned       CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TO_VAL = CNT_W'(TIMEOUT);

  state_t            state;
  logic              last_grant;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              enable_q;
  logic              write_q;
  logic              busy_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  wd_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      data_q     <= '0;
      addr_q     <= '0;
      enable_q   <= 1'b0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      wd_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Port 0 wins unless port 1 alone requests or port 0 was granted last.
          if (bus.req0_enable_i && (!bus.req1_enable_i || last_grant)) begin
            state      <= GRANT0;
            last_grant <= 1'b0;
            write_q    <= bus.req0_write_i;
            addr_q     <= bus.req0_addr_i;
            data_q     <= bus.req0_data_i;
            enable_q   <= 1'b1;
            busy_q     <= 1'b1;
            wd_cnt     <= '0;
          end else if (bus.req1_enable_i) begin
            state      <= GRANT1;
            last_grant <= 1'b1;
            write_q    <= bus.req1_write_i;
            addr_q     <= bus.req1_addr_i;
            data_q     <= bus.req1_data_i;
            enable_q   <= 1'b1;
            busy_q     <= 1'b1;
            wd_cnt     <= '0;
          end
        end
        GRANT0, GRANT1: begin
          if (bus.mem_ack_i) begin
            state    <= IDLE;
            enable_q <= 1'b0;
            write_q  <= 1'b0;
            busy_q   <= 1'b0;
          end else if (wd_cnt != TO_VAL) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt + 1'b1 == TO_VAL) timeout_q <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          enable_q <= 1'b0;
          write_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ack_o   = (state == GRANT0) && bus.mem_ack_i;
  assign bus.req1_ack_o   = (state == GRANT1) && bus.mem_ack_i;
  assign bus.rd_data_o    = bus.mem_data_i;
  assign bus.mem_data_o   = data_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_enable_o = enable_q;
  assign bus.mem_write_o  = write_q;
  assign bus.busy_o       = busy_q;
  assign bus.timeout_o    = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single reads/writes, fairness, request hold,
// idle acks, watchdog and asynchronous reset.
module tb_mem_arbiter;

  localparam int unsigned DATA_W  = 256;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TIMEOUT = 64;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  mem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Advance past the next rising edge; inputs and samples happen 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench time limit");
  end

  logic [255:0] pat_a5;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    pat_a5   = {32{8'hA5}};
    rst_n = 1'b0;
    bus.req0_enable_i = 0; bus.req0_write_i = 0; bus.req0_addr_i = '0; bus.req0_data_i = '0;
    bus.req1_enable_i = 0; bus.req1_write_i = 0; bus.req1_addr_i = '0; bus.req1_data_i = '0;
    bus.mem_data_i = '0;   bus.mem_ack_i = 0;
    step(); step();
    rst_n = 1'b1;
    check("rst_enable",  bus.mem_enable_o, 0);
    check("rst_busy",    bus.busy_o, 0);
    check("rst_timeout", bus.timeout_o, 0);
    check("rst_addr",    bus.mem_addr_o, 0);

    // Port 0 read, acked 3 cycles after enable rises.
    bus.req0_enable_i = 1; bus.req0_addr_i = 32'h0000_0400;
    step();
    check("r0_enable", bus.mem_enable_o, 1);
    check("r0_write",  bus.mem_write_o, 0);
    check("r0_addr",   bus.mem_addr_o, 32'h400);
    check("r0_busy",   bus.busy_o, 1);
    check("r0_noack",  bus.req0_ack_o, 0);
    step(); step();
    bus.mem_ack_i = 1; bus.mem_data_i = pat_a5;
    #1;
    check("r0_ack",    bus.req0_ack_o, 1);
    check("r0_ack1",   bus.req1_ack_o, 0);
    check("r0_rdata",  bus.rd_data_o, pat_a5);
    step();
    bus.mem_ack_i = 0; bus.req0_enable_i = 0;
    #1;
    check("r0_ack_gone", bus.req0_ack_o, 0);
    check("r0_done_en",  bus.mem_enable_o, 0);
    check("r0_hold_addr", bus.mem_addr_o, 32'h400);

    // Port 1 write.
    bus.req1_enable_i = 1; bus.req1_write_i = 1;
    bus.req1_addr_i = 32'h0000_0020; bus.req1_data_i = 256'h1234;
    step();
    check("w1_enable", bus.mem_enable_o, 1);
    check("w1_write",  bus.mem_write_o, 1);
    check("w1_addr",   bus.mem_addr_o, 32'h20);
    check("w1_data",   bus.mem_data_o, 256'h1234);
    step();
    check("w1_data_hold", bus.mem_data_o, 256'h1234);
    bus.mem_ack_i = 1;
    #1;
    check("w1_ack",  bus.req1_ack_o, 1);
    check("w1_ack0", bus.req0_ack_o, 0);
    step();
    bus.mem_ack_i = 0; bus.req1_enable_i = 0; bus.req1_write_i = 0;
    check("w1_done_en", bus.mem_enable_o, 0);
    check("w1_done_wr", bus.mem_write_o, 0);
    check("w1_keep_data", bus.mem_data_o, 256'h1234);
    step();
    check("w1_gap_busy", bus.busy_o, 0);

    // Both ports continuously requesting: 0,1,0,1 with one idle cycle between.
    bus.req0_addr_i = 32'hA0; bus.req1_addr_i = 32'hB0;
    bus.req0_enable_i = 1; bus.req1_enable_i = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_busy", bus.busy_o, 1);
      check("rr_addr", bus.mem_addr_o, (i % 2 == 0) ? 32'hA0 : 32'hB0);
      bus.mem_ack_i = 1;
      #1;
      check("rr_ack0", bus.req0_ack_o, (i % 2 == 0) ? 1 : 0);
      check("rr_ack1", bus.req1_ack_o, (i % 2 == 0) ? 0 : 1);
      step();
      bus.mem_ack_i = 0;
      check("rr_gap", bus.busy_o, 0);
    end
    bus.req0_enable_i = 0; bus.req1_enable_i = 0;
    step();

    // Request inputs ignored during GRANT1.
    bus.req1_enable_i = 1; bus.req1_addr_i = 32'h300;
    step();
    check("hold_addr0", bus.mem_addr_o, 32'h300);
    bus.req1_addr_i = 32'h999; bus.req1_enable_i = 0;
    step();
    check("hold_addr1", bus.mem_addr_o, 32'h300);
    check("hold_busy",  bus.busy_o, 1);
    bus.mem_ack_i = 1;
    #1;
    check("hold_ack", bus.req1_ack_o, 1);
    step();
    bus.mem_ack_i = 0;

    // Ack while idle is ignored.
    step();
    bus.mem_ack_i = 1;
    #1;
    check("idle_ack0", bus.req0_ack_o, 0);
    check("idle_ack1", bus.req1_ack_o, 0);
    step();
    bus.mem_ack_i = 0;
    check("idle_busy", bus.busy_o, 0);
    check("idle_en",   bus.mem_enable_o, 0);

    // Watchdog: no ack for TIMEOUT cycles inside a grant.
    bus.req0_enable_i = 1; bus.req0_addr_i = 32'h40;
    step();
    bus.req0_enable_i = 0;
    check("wd_busy", bus.busy_o, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    check("wd_before", bus.timeout_o, 0);
    step();
    check("wd_set", bus.timeout_o, 1);
    check("wd_still_busy", bus.busy_o, 1);
    bus.mem_ack_i = 1;
    #1;
    check("wd_ack", bus.req0_ack_o, 1);
    step();
    bus.mem_ack_i = 0;
    check("wd_sticky", bus.timeout_o, 1);
    check("wd_idle", bus.busy_o, 0);

    // Asynchronous reset in the middle of GRANT0.
    bus.req0_enable_i = 1; bus.req0_addr_i = 32'h50; bus.req0_write_i = 1;
    step();
    check("ar_busy", bus.busy_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_enable",  bus.mem_enable_o, 0);
    check("ar_write",   bus.mem_write_o, 0);
    check("ar_addr",    bus.mem_addr_o, 0);
    check("ar_busy0",   bus.busy_o, 0);
    check("ar_timeout", bus.timeout_o, 0);
    bus.mem_ack_i = 1;
    #1;
    check("ar_noack", bus.req0_ack_o, 0);
    bus.mem_ack_i = 0; bus.req0_write_i = 0;
    bus.req0_addr_i = 32'h60; bus.req1_addr_i = 32'h70;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req1_enable_i = 1;
    step();
    check("ar_tie_busy", bus.busy_o, 1);
    check("ar_tie_addr", bus.mem_addr_o, 32'h60);
    bus.req0_enable_i = 0; bus.req1_enable_i = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single 256-bit Data Memory port between instruction-side refill (port 0) and dcache (port 1).
- Sits between the cache controllers and the top-level memory interface (mem_data_i/mem_ack_i/mem_data_o/mem_addr_o/mem_enable_o/mem_write_o).
- Round-robin grant; captures the granted request into registers and holds it until mem_ack_i.
- Includes a per-transaction watchdog.

Parameters:
- DATA_W, 256, memory line width in bits.
- ADDR_W, 32, address width in bits.
- TIMEOUT, 64, cycles in a grant without mem_ack_i before timeout_o sets; minimum value 2.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req0_enable_i  in  1  port 0 request; held high until req0_ack_o.
- req0_write_i  in  1  port 0: 1 = write, 0 = read.
- req0_addr_i  in  ADDR_W  port 0 line address.
- req0_data_i  in  DATA_W  port 0 write data.
- req0_ack_o  out  1  port 0 completion pulse, one cycle.
- req1_enable_i / req1_write_i / req1_addr_i / req1_data_i / req1_ack_o  same as port 0, for port 1 (dcache).
- rd_data_o  out  DATA_W  mem_data_i passed through to both ports; valid when an ack_o is high.
- mem_data_i  in  DATA_W  memory read data.
- mem_ack_i  in  1  memory completion pulse.
- mem_data_o  out  DATA_W  registered write data.
- mem_addr_o  out  ADDR_W  registered address.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  memory write strobe.
- busy_o  out  1  high in either GRANT state.
- timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst_i low, asynchronous):
  - State goes to IDLE; the last-granted pointer is set to 1, so port 0 wins the first tie.
  - mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, busy_o, timeout_o and the watchdog counter all go to 0.
  - An in-flight transaction is abandoned; no ack is issued for it.
- States are IDLE, GRANT0 and GRANT1.
- IDLE:
  - Arbitration is sampled at the clock edge.
  - Only one requester enabled: grant it.
  - Both enabled: grant the port that is not the last-granted one, then update the pointer.
  - Neither enabled: stay in IDLE.
  - On a grant: capture that port's write, addr and data into the mem_* registers, set mem_enable_o=1, and enter GRANTx.
  - Latency: request high at edge N gives mem_enable_o high after edge N.
- GRANTx:
  - mem_* outputs are held constant.
  - Changes on the request inputs are ignored, including enable dropping. The transaction still completes and the ack is still pulsed.
- Completion:
  - While in GRANTx, mem_ack_i=1 drives reqx_ack_o=1 combinationally in the same cycle, with rd_data_o = mem_data_i.
  - At the next edge: state goes to IDLE; mem_enable_o and mem_write_o go to 0; mem_addr_o and mem_data_o keep their values.
- Mandatory IDLE cycle:
  - At least one IDLE cycle separates consecutive grants.
  - This lets the acked requester drop its enable before the next arbitration, so no stale request is reissued.
- mem_ack_i seen in IDLE is ignored; both ack outputs stay 0.
- Ack isolation: reqx_ack_o is never high unless state is GRANTx. The two acks are never high together.
- Watchdog:
  - The counter clears on entry to GRANTx and increments each cycle in GRANTx without an ack.
  - When it reaches TIMEOUT, timeout_o goes to 1 and stays there until reset. The counter saturates.
  - The grant keeps waiting; there is no abort.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1…

Test Plan:
- Reset, then req0 read with addr=0x0000_0400; memory acks 3 cycles after enable with data=256'hA5…A5 → mem_enable_o high 1 cycle after the request; mem_write_o=0; mem_addr_o=0x400; req0_ack_o pulses once with rd_data_o=A5…A5; req1_ack_o stays 0.
- req1 write with addr=0x0000_0020, data=256'h1234 → mem_write_o=1, mem_data_o=256'h1234 until ack; then mem_enable_o=0 and the IDLE gap cycle is present.
- req0 and req1 both asserted continuously for 4 transactions → grant order 0,1,0,1; each grant separated by exactly one IDLE cycle.
- During GRANT1, change req1_addr_i to 0x999 and drop req1_enable_i → mem_addr_o is unchanged and req1_ack_o still pulses on mem_ack_i.
- mem_ack_i pulsed while IDLE → no ack output, no state change. During a grant, mem_ack_i withheld for 64 cycles → timeout_o=1 and stays set after a later ack.
- Assert rst_i low mid-GRANT0 → all outputs 0 immediately (asynchronously); after release the next tie grants port 0 first.
